// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbiter sharing one main-memory port between I-cache block refills and
// single-word D-side accesses, with round-robin tie breaking.
module ucsbece154b_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           IReq_i,
  input  logic [ADDR_WIDTH-1:0]          IAddr_i,
  output logic                           IDataValid_o,
  output logic [DATA_WIDTH-1:0]          IData_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] IWordIdx_o,
  output logic                           IDone_o,

  input  logic                           DReq_i,
  input  logic                           DWe_i,
  input  logic [ADDR_WIDTH-1:0]          DAddr_i,
  input  logic [DATA_WIDTH-1:0]          DWData_i,
  output logic [DATA_WIDTH-1:0]          DRData_o,
  output logic                           DDone_o,

  output logic                           MemReq_o,
  output logic                           MemWe_o,
  output logic [ADDR_WIDTH-1:0]          MemAddr_o,
  output logic [DATA_WIDTH-1:0]          MemWData_o,
  output logic                           MemBurst_o,
  input  logic                           MemGnt_i,
  input  logic                           MemRValid_i,
  input  logic [DATA_WIDTH-1:0]          MemRData_i
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    I_DATA,
    D_REQ,
    D_DATA
  } state_t;

  state_t            state;
  logic              lastGntD;
  logic [IDX_W-1:0]  wordCount;
  logic              lastBeat;

  assign lastBeat = (wordCount == IDX_W'(BLOCK_WORDS - 1));

  // lastGntD remembers who won most recently; a tie goes to the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lastGntD  <= 1'b0;
      wordCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IReq_i && DReq_i) begin
            if (lastGntD) begin
              state    <= I_REQ;
              lastGntD <= 1'b0;
            end else begin
              state    <= D_REQ;
              lastGntD <= 1'b1;
            end
          end else if (IReq_i) begin
            state    <= I_REQ;
            lastGntD <= 1'b0;
          end else if (DReq_i) begin
            state    <= D_REQ;
            lastGntD <= 1'b1;
          end
        end
        I_REQ: begin
          if (MemGnt_i) begin
            state     <= I_DATA;
            wordCount <= '0;
          end
        end
        I_DATA: begin
          if (MemRValid_i) begin
            if (lastBeat) begin
              wordCount <= '0;
              state     <= IDLE;
            end else begin
              wordCount <= wordCount + IDX_W'(1);
            end
          end
        end
        D_REQ: begin
          if (MemGnt_i) begin
            state <= DWe_i ? IDLE : D_DATA;
          end
        end
        D_DATA: begin
          if (MemRValid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side drive depends only on state and the held request inputs;
  // requester-side pulses follow the memory handshake combinationally.
  always_comb begin
    MemReq_o     = 1'b0;
    MemWe_o      = 1'b0;
    MemAddr_o    = '0;
    MemWData_o   = '0;
    MemBurst_o   = 1'b0;
    IDataValid_o = 1'b0;
    IData_o      = '0;
    IWordIdx_o   = '0;
    IDone_o      = 1'b0;
    DRData_o     = '0;
    DDone_o      = 1'b0;
    case (state)
      I_REQ: begin
        MemReq_o   = 1'b1;
        MemBurst_o = 1'b1;
        MemAddr_o  = IAddr_i;
      end
      I_DATA: begin
        if (MemRValid_i) begin
          IDataValid_o = 1'b1;
          IData_o      = MemRData_i;
          IWordIdx_o   = wordCount;
          IDone_o      = lastBeat;
        end
      end
      D_REQ: begin
        MemReq_o   = 1'b1;
        MemWe_o    = DWe_i;
        MemAddr_o  = DAddr_i;
        MemWData_o = DWData_i;
        DDone_o    = MemGnt_i && DWe_i;
      end
      D_DATA: begin
        if (MemRValid_i) begin
          DDone_o  = 1'b1;
          DRData_o = MemRData_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for ucsbece154b_mem_arbiter; memory handshake driven by hand.
module tb_ucsbece154b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq_i;
  logic [31:0] IAddr_i;
  logic        IDataValid_o;
  logic [31:0] IData_o;
  logic [1:0]  IWordIdx_o;
  logic        IDone_o;
  logic        DReq_i;
  logic        DWe_i;
  logic [31:0] DAddr_i;
  logic [31:0] DWData_i;
  logic [31:0] DRData_o;
  logic        DDone_o;
  logic        MemReq_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWData_o;
  logic        MemBurst_o;
  logic        MemGnt_i;
  logic        MemRValid_i;
  logic [31:0] MemRData_i;

  int testsRun = 0;
  int testsFailed = 0;

  ucsbece154b_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IDataValid_o(IDataValid_o),
    .IData_o(IData_o), .IWordIdx_o(IWordIdx_o), .IDone_o(IDone_o),
    .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWData_i(DWData_i),
    .DRData_o(DRData_o), .DDone_o(DDone_o),
    .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
    .MemWData_o(MemWData_o), .MemBurst_o(MemBurst_o), .MemGnt_i(MemGnt_i),
    .MemRValid_i(MemRValid_i), .MemRData_i(MemRData_i)
  );

  always #5 clk = ~clk;

  // Each cycle: inputs change at posedge+2, checks happen at posedge+4.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyReset();
    IReq_i = 0; IAddr_i = 0; DReq_i = 0; DWe_i = 0; DAddr_i = 0; DWData_i = 0;
    MemGnt_i = 0; MemRValid_i = 0; MemRData_i = 0;
    reset = 1;
    nextCycle();
    nextCycle();
    reset = 0;
  endtask

  task automatic test_reset();
    applyReset();
    settle();
    testsRun++;
    if ({MemReq_o, MemWe_o, MemBurst_o, IDataValid_o, IDone_o, DDone_o} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {MemReq_o, MemWe_o, MemBurst_o, IDataValid_o, IDone_o, DDone_o});
    end
    testsRun++;
    if ({MemAddr_o, MemWData_o, IData_o, DRData_o, IWordIdx_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: addr %h wdata %h idata %h drdata %h idx %0d, expected all 0",
               MemAddr_o, MemWData_o, IData_o, DRData_o, IWordIdx_o);
    end
  endtask

  task automatic test_d_write();
    applyReset();
    DReq_i = 1; DWe_i = 1; DAddr_i = 32'h100; DWData_i = 32'hDEADBEEF; MemGnt_i = 1;
    settle();
    testsRun++;
    if (MemReq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dwr_idle_req: got %b expected 0", MemReq_o);
    end
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemWe_o, MemBurst_o, DDone_o} !== 4'b1101) begin
      testsFailed++;
      $display("[TB] FAIL dwr_ctrl: req/we/burst/done got %b expected 1101",
               {MemReq_o, MemWe_o, MemBurst_o, DDone_o});
    end
    testsRun++;
    if (MemAddr_o !== 32'h100 || MemWData_o !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL dwr_bus: addr %h wdata %h expected 00000100 deadbeef",
               MemAddr_o, MemWData_o);
    end
    nextCycle();
    DReq_i = 0;
    settle();
    testsRun++;
    if ({MemReq_o, DDone_o, MemAddr_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL dwr_back_idle: req %b done %b addr %h expected 0 0 0",
               MemReq_o, DDone_o, MemAddr_o);
    end
  endtask

  task automatic test_i_refill();
    int pulses;
    logic expValid;
    logic [31:0] expData;
    applyReset();
    pulses = 0;
    IReq_i = 1; IAddr_i = 32'h200; MemGnt_i = 1;
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemBurst_o, MemWe_o} !== 3'b110 || MemAddr_o !== 32'h200) begin
      testsFailed++;
      $display("[TB] FAIL iref_req: req/burst/we %b addr %h expected 110 00000200",
               {MemReq_o, MemBurst_o, MemWe_o}, MemAddr_o);
    end
    for (int b = 0; b < 7; b++) begin
      nextCycle();
      expValid = (b % 2 == 0);
      expData = expValid ? 32'hA0 + 32'(b / 2) : 32'h0;
      MemRValid_i = expValid;
      MemRData_i = expValid ? expData : 32'h0;
      settle();
      if (IDataValid_o === 1'b1) pulses++;
      testsRun++;
      if (IDataValid_o !== expValid || IData_o !== expData ||
          IWordIdx_o !== (expValid ? 2'(b / 2) : 2'd0) || IDone_o !== (b == 6) ||
          MemReq_o !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL iref_beat%0d: valid %b data %h idx %0d done %b req %b, expected %b %h %0d %b 0",
                 b, IDataValid_o, IData_o, IWordIdx_o, IDone_o, MemReq_o,
                 expValid, expData, (expValid ? b / 2 : 0), (b == 6));
      end
    end
    nextCycle();
    IReq_i = 0; MemRValid_i = 0; MemRData_i = 0;
    settle();
    testsRun++;
    if (pulses != 4 || MemReq_o !== 1'b0 || IDataValid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL iref_end: pulses %0d req %b valid %b expected 4 0 0",
               pulses, MemReq_o, IDataValid_o);
    end
  endtask

  task automatic test_tie();
    applyReset();
    IReq_i = 1; IAddr_i = 32'h400; DReq_i = 1; DWe_i = 1; DAddr_i = 32'h44;
    DWData_i = 32'h1234; MemGnt_i = 1;
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemBurst_o, DDone_o} !== 3'b101) begin
      testsFailed++;
      $display("[TB] FAIL tie1_d_first: req/burst/done %b expected 101",
               {MemReq_o, MemBurst_o, DDone_o});
    end
    nextCycle();
    DReq_i = 0;
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemBurst_o} !== 2'b11 || MemAddr_o !== 32'h400) begin
      testsFailed++;
      $display("[TB] FAIL tie_i_next: req/burst %b addr %h expected 11 00000400",
               {MemReq_o, MemBurst_o}, MemAddr_o);
    end
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      MemRValid_i = 1; MemRData_i = 32'h10 + 32'(b);
      settle();
      testsRun++;
      if (IDone_o !== (b == 3)) begin
        testsFailed++;
        $display("[TB] FAIL tie_idone%0d: got %b expected %b", b, IDone_o, (b == 3));
      end
    end
    nextCycle();
    MemRValid_i = 0; MemRData_i = 0; DReq_i = 1;
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemBurst_o, MemWe_o, DDone_o} !== 4'b1011) begin
      testsFailed++;
      $display("[TB] FAIL tie2_d_again: req/burst/we/done %b expected 1011",
               {MemReq_o, MemBurst_o, MemWe_o, DDone_o});
    end
    nextCycle();
    DReq_i = 0; IReq_i = 0;
  endtask

  task automatic test_no_starvation();
    logic expI;
    applyReset();
    IReq_i = 1; IAddr_i = 32'h800; DReq_i = 1; DWe_i = 1; DAddr_i = 32'h88;
    DWData_i = 32'h5A5A; MemGnt_i = 1;
    for (int k = 0; k < 3; k++) begin
      expI = (k == 1);
      nextCycle();
      settle();
      testsRun++;
      if ({MemReq_o, MemBurst_o} !== {1'b1, expI}) begin
        testsFailed++;
        $display("[TB] FAIL starve_grant%0d: req/burst %b expected 1%b",
                 k, {MemReq_o, MemBurst_o}, expI);
      end
      if (expI) begin
        for (int b = 0; b < 4; b++) begin
          nextCycle();
          MemRValid_i = 1; MemRData_i = 32'h20 + 32'(b);
        end
        nextCycle();
        MemRValid_i = 0; MemRData_i = 0;
      end else begin
        nextCycle();
      end
    end
    IReq_i = 0; DReq_i = 0;
  endtask

  task automatic test_reset_mid_refill();
    applyReset();
    IReq_i = 1; IAddr_i = 32'hC00; MemGnt_i = 1;
    nextCycle();
    nextCycle();
    MemRValid_i = 1; MemRData_i = 32'hB0;
    nextCycle();
    MemRData_i = 32'hB1;
    settle();
    testsRun++;
    if (IDataValid_o !== 1'b1 || IWordIdx_o !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_word1: valid %b idx %0d expected 1 1", IDataValid_o, IWordIdx_o);
    end
    nextCycle();
    reset = 1; MemRValid_i = 0; MemRData_i = 0;
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      reset = 0; IReq_i = 0; MemRValid_i = 1; MemRData_i = 32'hB2 + 32'(c);
      settle();
      testsRun++;
      if ({IDataValid_o, IDone_o, MemReq_o, MemBurst_o} !== 4'b0 || IData_o !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL rst_mid_quiet%0d: valid/done/req/burst %b idata %h expected 0000 0",
                 c, {IDataValid_o, IDone_o, MemReq_o, MemBurst_o}, IData_o);
      end
    end
    MemRValid_i = 0; MemRData_i = 0;
  endtask

  task automatic test_spurious_and_drop();
    applyReset();
    for (int c = 0; c < 2; c++) begin
      MemRValid_i = 1; MemRData_i = 32'h55;
      settle();
      testsRun++;
      if ({IDataValid_o, DDone_o, IDone_o} !== 3'b0 || DRData_o !== 0 || IData_o !== 0) begin
        testsFailed++;
        $display("[TB] FAIL spur_idle%0d: ivalid/ddone/idone %b drdata %h idata %h expected 000 0 0",
                 c, {IDataValid_o, DDone_o, IDone_o}, DRData_o, IData_o);
      end
      nextCycle();
    end
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h300; MemGnt_i = 0;
    nextCycle();
    settle();
    testsRun++;
    if ({MemReq_o, MemWe_o, DDone_o} !== 3'b100 || MemAddr_o !== 32'h300) begin
      testsFailed++;
      $display("[TB] FAIL rd_req_wait: req/we/done %b addr %h expected 100 00000300",
               {MemReq_o, MemWe_o, DDone_o}, MemAddr_o);
    end
    nextCycle();
    MemGnt_i = 1; MemRValid_i = 0; MemRData_i = 0;
    settle();
    testsRun++;
    if (DDone_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rd_gnt_nodone: got %b expected 0", DDone_o);
    end
    nextCycle();
    DReq_i = 0; MemGnt_i = 0;
    settle();
    testsRun++;
    if (DDone_o !== 1'b0 || MemReq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rd_wait_data: done %b req %b expected 0 0", DDone_o, MemReq_o);
    end
    nextCycle();
    MemRValid_i = 1; MemRData_i = 32'hCAFEF00D;
    settle();
    testsRun++;
    if (DDone_o !== 1'b1 || DRData_o !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("[TB] FAIL rd_done: done %b data %h expected 1 cafef00d", DDone_o, DRData_o);
    end
    nextCycle();
    MemRValid_i = 1; MemRData_i = 32'h77;
    settle();
    testsRun++;
    if (DDone_o !== 1'b0 || DRData_o !== 32'h0 || MemReq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rd_after: done %b data %h req %b expected 0 0 0",
               DDone_o, DRData_o, MemReq_o);
    end
    MemRValid_i = 0; MemRData_i = 0;
  endtask

  initial begin
    test_reset();
    test_d_write();
    test_i_refill();
    test_tie();
    test_no_starvation();
    test_reset_mid_refill();
    test_spurious_and_drop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
